vga_display_ctrl: RTL and testbench

- Sequences the 640x480 VGA display: generates the pixel strobe, horizontal/vertical counters, Hsync/Vsync and active-region flags.
- Arbitrates the shared RGB output among three drawing requesters using fixed priority.
- Forces RGB to 0 outside the active region.
- Sits between the game/drawing logic and the top-level vgaRed/vgaGreen/vgaBlue/Hsync/Vsync pins; all pin-facing outputs are registered.

---
 rtl/vga_display_ctrl.sv | 134 +++++++++++++
 tb/tb_vga_display_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_display_ctrl : 640x480 VGA timing, fixed-priority RGB arbitration       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_display_ctrl #(
    parameter int          PIX_DIV      = 4,
    parameter int          H_TOTAL      = 800,
    parameter int          V_TOTAL      = 525,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          H_ACTIVE     = 640,
    parameter int          H_SYNC_START = 655,
    parameter int          H_SYNC_END   = 750,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_SYNC_START = 489,
    parameter int          V_SYNC_END   = 490
) (
    input  logic        clk,
    input  logic        greset,
    input  logic [2:0]  req,
    input  logic [11:0] color0,
    input  logic [11:0] color1,
    input  logic [11:0] color2,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        pix_en,
    output logic        frame_tick,
    output logic [2:0]  grant,
    output logic        Hsync,
    output logic        Vsync,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue
);

    localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       H_SS     = 10'(H_SYNC_START);
    localparam logic [9:0]       H_SE     = 10'(H_SYNC_END);
    localparam logic [9:0]       V_SS     = 10'(V_SYNC_START);
    localparam logic [9:0]       V_SE     = 10'(V_SYNC_END);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [11:0]      rgb_q, rgb_d;
    logic [2:0]       grant_q, grant_d;

    logic             w_pix_en;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;

    always_comb begin
        w_pix_en = (div_q == DIV_LAST);
        w_h_wrap = (hcount_q == H_LAST);
        w_v_wrap = (vcount_q == V_LAST);
        w_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);

        div_d    = w_pix_en ? '0 : div_q + 1'b1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        rgb_d    = rgb_q;
        grant_d  = grant_q;

        if (w_pix_en) begin
            hcount_d = w_h_wrap ? 10'd0 : hcount_q + 10'd1;
            if (w_h_wrap) begin
                vcount_d = w_v_wrap ? 10'd0 : vcount_q + 10'd1;
            end

            // Output stage decodes the pixel being left, so sync and colour stay aligned.
            hsync_d = !((hcount_q >= H_SS) && (hcount_q <= H_SE));
            vsync_d = !((vcount_q >= V_SS) && (vcount_q <= V_SE));
            rgb_d   = 12'h000;
            grant_d = 3'b000;
            if (w_active) begin
                if (req[0]) begin
                    rgb_d   = color0;
                    grant_d = 3'b001;
                end else if (req[1]) begin
                    rgb_d   = color1;
                    grant_d = 3'b010;
                end else if (req[2]) begin
                    rgb_d   = color2;
                    grant_d = 3'b100;
                end else begin
                    rgb_d   = BG_COLOR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            div_q    <= '0;
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= 12'h000;
            grant_q  <= 3'b000;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_q    <= rgb_d;
            grant_q  <= grant_d;
        end
    end

    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign pix_en     = w_pix_en;
    assign frame_tick = w_pix_en & w_h_wrap & w_v_wrap;
    assign grant      = grant_q;
    assign Hsync      = hsync_q;
    assign Vsync      = vsync_q;
    assign vgaRed     = rgb_q[11:8];
    assign vgaGreen   = rgb_q[7:4];
    assign vgaBlue    = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_display_ctrl : directed checks of vga_display_ctrl timing/arbiter   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_display_ctrl;

    localparam logic [11:0] COL0 = 12'hF00;
    localparam logic [11:0] COL1 = 12'h0F0;
    localparam logic [11:0] COL2 = 12'h00F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        greset0 = 1'b1;
    logic        greset1 = 1'b1;
    logic [2:0]  req0 = 3'b000;
    logic [2:0]  req1;
    logic [11:0] col0 = COL0;
    logic [11:0] col1 = COL1;
    logic [11:0] col2 = COL2;

    logic [9:0] hcount0, vcount0, hcount1, vcount1;
    logic       pix_en0, frame_tick0, Hsync0, Vsync0;
    logic       pix_en1, frame_tick1, Hsync1, Vsync1;
    logic [2:0] grant0, grant1;
    logic [3:0] vgaRed0, vgaGreen0, vgaBlue0, vgaRed1, vgaGreen1, vgaBlue1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k0       = 0;
    int k1       = 0;

    // Full-size display
    vga_display_ctrl u0 (
        .clk(clk), .greset(greset0), .req(req0),
        .color0(col0), .color1(col1), .color2(col2),
        .hcount(hcount0), .vcount(vcount0), .pix_en(pix_en0), .frame_tick(frame_tick0),
        .grant(grant0), .Hsync(Hsync0), .Vsync(Vsync0),
        .vgaRed(vgaRed0), .vgaGreen(vgaGreen0), .vgaBlue(vgaBlue0)
    );

    // Shrunken frame so vertical timing and whole frames fit in a short run
    vga_display_ctrl #(
        .PIX_DIV(4), .H_TOTAL(20), .V_TOTAL(12), .BG_COLOR(12'h5A3),
        .H_ACTIVE(12), .H_SYNC_START(14), .H_SYNC_END(16),
        .V_ACTIVE(8), .V_SYNC_START(9), .V_SYNC_END(10)
    ) u1 (
        .clk(clk), .greset(greset1), .req(req1),
        .color0(col0), .color1(col1), .color2(col2),
        .hcount(hcount1), .vcount(vcount1), .pix_en(pix_en1), .frame_tick(frame_tick1),
        .grant(grant1), .Hsync(Hsync1), .Vsync(Vsync1),
        .vgaRed(vgaRed1), .vgaGreen(vgaGreen1), .vgaBlue(vgaBlue1)
    );

    function automatic logic [2:0] req_f(input int h, input int v);
        logic [9:0] hh;
        logic [9:0] vv;
        hh = 10'(h);
        vv = 10'(v);
        return {hh[2] ^ vv[0], hh[1], hh[0]};
    endfunction

    assign req1 = req_f(int'(hcount1), int'(vcount1));

    // Closed-form expectation after k clock edges since reset release:
    // {hcount, vcount, pix_en, frame_tick, Hsync, Vsync, rgb, grant}
    function automatic logic [38:0] model(input int k, input int pd, input int ht, input int vt,
                                          input int ha, input int hs0, input int hs1,
                                          input int va, input int vs0, input int vs1,
                                          input logic [11:0] bg);
        int n, p, ph, pv, ch, cv;
        logic pe, ft, hs, vs;
        logic [11:0] rgb;
        logic [2:0]  g, rq;
        n   = k / pd;
        ch  = n % ht;
        cv  = (n / ht) % vt;
        pe  = (k % pd) == pd - 1;
        ft  = pe && (ch == ht - 1) && (cv == vt - 1);
        hs  = 1'b1;
        vs  = 1'b1;
        rgb = 12'h000;
        g   = 3'b000;
        if (n > 0) begin
            p  = n - 1;
            ph = p % ht;
            pv = (p / ht) % vt;
            hs = !(ph >= hs0 && ph <= hs1);
            vs = !(pv >= vs0 && pv <= vs1);
            if (ph < ha && pv < va) begin
                rq = req_f(ph, pv);
                if (rq[0])      begin rgb = COL0; g = 3'b001; end
                else if (rq[1]) begin rgb = COL1; g = 3'b010; end
                else if (rq[2]) begin rgb = COL2; g = 3'b100; end
                else            begin rgb = bg; end
            end
        end
        return {10'(ch), 10'(cv), pe, ft, hs, vs, rgb, g};
    endfunction

    function automatic logic [23:0] seq_part(input logic [38:0] x);
        return x[38:15];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge greset0) begin
        if (!greset0) k0 <= 0;
        else          k0 <= k0 + 1;
    end

    always @(posedge clk or negedge greset1) begin
        if (!greset1) k1 <= 0;
        else          k1 <= k1 + 1;
    end

    always @(negedge clk) begin
        check("u0_seq", {hcount0, vcount0, pix_en0, frame_tick0, Hsync0, Vsync0},
              seq_part(model(k0, 4, 800, 525, 640, 655, 750, 480, 489, 490, 12'h000)));
        check("u1_all", {hcount1, vcount1, pix_en1, frame_tick1, Hsync1, Vsync1,
                         vgaRed1, vgaGreen1, vgaBlue1, grant1},
              model(k1, 4, 20, 12, 12, 14, 16, 8, 9, 10, 12'h5A3));
    end

    task automatic wait_u0_px(input logic [9:0] h, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (pix_en0 && hcount0 == h) begin ok = 1'b1; break; end
        end
        check("u0_px_wait", 64'(ok), 64'd1);
    endtask

    task automatic next_px0();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pix_en0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("u0_next_px", 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_u0_hs(input logic lvl, output int at, output int pe_at);
        at    = -1;
        pe_at = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (pix_en0 && hcount0 == 10'd655) pe_at = cyc;
            if (Hsync0 === lvl) begin at = cyc; break; end
        end
        check("u0_hs_wait", 64'(at >= 0), 64'd1);
    endtask

    task automatic wait_u1_ft(output int at);
        at = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (frame_tick1) begin at = cyc; break; end
        end
        check("u1_ft_wait", 64'(at >= 0), 64'd1);
    endtask

    initial begin
        int fall, rise, pe, prev_fall, t0, t1, dummy;
        logic found;

        // Reset state
        #1 greset0 = 1'b0; greset1 = 1'b0;
        #1;
        check("u0_reset", {hcount0, vcount0, pix_en0, frame_tick0, Hsync0, Vsync0,
                           vgaRed0, vgaGreen0, vgaBlue0, grant0},
              {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 3'b000});
        check("u1_reset", {hcount1, vcount1, pix_en1, frame_tick1, Hsync1, Vsync1,
                           vgaRed1, vgaGreen1, vgaBlue1, grant1},
              {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 3'b000});
        #40 greset0 = 1'b1; greset1 = 1'b1;

        // First strobe on the 4th edge after release
        @(negedge clk); check("pe_edge1", 64'(pix_en0), 64'd0);
        @(negedge clk); check("pe_edge2", 64'(pix_en0), 64'd0);
        @(negedge clk); check("pe_edge3", 64'(pix_en0), 64'd1);
        check("pre_update", {Hsync0, Vsync0, vgaRed0, vgaGreen0, vgaBlue0, hcount0},
              {1'b1, 1'b1, 12'h000, 10'd0});
        @(negedge clk);
        check("first_px_u0", {hcount0, vcount0, Hsync0, vgaRed0, vgaGreen0, vgaBlue0, grant0},
              {10'd1, 10'd0, 1'b1, 12'h000, 3'b000});
        check("first_px_u1_bg", {vgaRed1, vgaGreen1, vgaBlue1, grant1}, {12'h5A3, 3'b000});

        // Hsync placement, width and line period over 3 lines
        prev_fall = 0;
        for (int l = 0; l < 3; l++) begin
            wait_u0_hs(1'b0, fall, pe);
            check("hs_fall_delay", 64'(fall - pe), 64'd1);
            if (l > 0) check("line_period", 64'(fall - prev_fall), 64'd3200);
            wait_u0_hs(1'b1, rise, dummy);
            check("hs_low_clks", 64'(rise - fall), 64'd384);
            prev_fall = fall;
        end

        // Priority and horizontal blanking boundary on line 3
        req0 = 3'b111;
        wait_u0_px(10'd20, 1200);
        @(negedge clk);
        check("prio_111", {vgaRed0, vgaGreen0, vgaBlue0, grant0}, {12'hF00, 3'b001});
        wait_u0_px(10'd639, 3000);
        @(negedge clk);
        check("last_active", {vgaRed0, vgaGreen0, vgaBlue0, grant0}, {12'hF00, 3'b001});
        next_px0();
        check("hblank_640", {vgaRed0, vgaGreen0, vgaBlue0, grant0}, {12'h000, 3'b000});

        wait_u0_px(10'd5, 1200);
        req0 = 3'b110;
        @(negedge clk);
        check("prio_110", {vgaRed0, vgaGreen0, vgaBlue0, grant0}, {12'h0F0, 3'b010});
        req0 = 3'b100;
        next_px0();
        check("prio_100", {vgaRed0, vgaGreen0, vgaBlue0, grant0}, {12'h00F, 3'b100});
        req0 = 3'b000;
        next_px0();
        check("prio_none", {vgaRed0, vgaGreen0, vgaBlue0, grant0}, {12'h000, 3'b000});

        // Frame period and Vsync on the shrunken frame (20 x 12 pixels)
        wait_u1_ft(t0);
        @(negedge clk);
        wait_u1_ft(t1);
        check("frame_period", 64'(t1 - t0), 64'd960);

        found = 1'b0;
        pe    = -1;
        fall  = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (pix_en1 && hcount1 == 10'd0 && vcount1 == 10'd9) pe = cyc;
            if (!Vsync1) begin fall = cyc; found = 1'b1; break; end
        end
        check("vs_fall_wait", 64'(found), 64'd1);
        check("vs_fall_delay", 64'(fall - pe), 64'd1);
        found = 1'b0;
        rise  = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (Vsync1) begin rise = cyc; found = 1'b1; break; end
        end
        check("vs_rise_wait", 64'(found), 64'd1);
        check("vs_low_clks", 64'(rise - fall), 64'd160);

        // Mid-frame reset
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (pix_en1 && hcount1 == 10'd7 && vcount1 == 10'd5) begin found = 1'b1; break; end
        end
        check("mid_rst_wait", 64'(found), 64'd1);
        #2 greset1 = 1'b0;
        #1;
        check("mid_rst_vals", {hcount1, vcount1, pix_en1, frame_tick1, Hsync1, Vsync1,
                               vgaRed1, vgaGreen1, vgaBlue1, grant1},
              {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 3'b000});
        #29 greset1 = 1'b1;
        @(negedge clk); check("rst_pe_edge1", 64'(pix_en1), 64'd0);
        @(negedge clk); check("rst_pe_edge2", 64'(pix_en1), 64'd0);
        @(negedge clk);
        check("rst_pe_edge3", {pix_en1, hcount1, vcount1}, {1'b1, 10'd0, 10'd0});
        @(negedge clk);
        check("rst_restart", {pix_en1, hcount1, vcount1}, {1'b0, 10'd1, 10'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
